// File: rtl/issue_sequencer_if.sv
// Fetch, issue, write-back and debug-halt signals of the issue sequencer.
// The slave modport is the sequencer side; the master modport drives it.
interface issue_sequencer_if;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic        instr_ready;
  logic        program_counter_inc;
  logic        issue_valid;
  logic [31:0] issue_instr;
  logic        issue_ready;
  logic        wb_valid;
  logic [3:0]  wb_y1_reg;
  logic [3:0]  wb_y2_reg;
  logic [1:0]  wb_write;
  logic        halt_req;
  logic        halted;
  logic [15:0] pending;

  modport slave (
    input  instr_valid, instr_data, issue_ready, halt_req,
    output instr_ready, program_counter_inc, issue_valid, issue_instr,
           wb_valid, wb_y1_reg, wb_y2_reg, wb_write, halted, pending
  );

  modport master (
    output instr_valid, instr_data, issue_ready, halt_req,
    input  instr_ready, program_counter_inc, issue_valid, issue_instr,
           wb_valid, wb_y1_reg, wb_y2_reg, wb_write, halted, pending
  );
endinterface

// File: rtl/issue_sequencer.sv
// In-order issue from a fetch FIFO with a RAW/WAW scoreboard, fixed-latency retire and halt/drain.
// Fetch-to-issue 1 cycle, issue-to-retire ALU_LATENCY; SCOREBOARD_BYPASS_EN lets a retiring bit count as clear.
module issue_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ALU_LATENCY = 3
) (
  input  logic clk,
  input  logic reset,
  issue_sequencer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  typedef struct packed {
    logic       vld;
    logic [3:0] y1;
    logic [3:0] y2;
    logic [1:0] wr;
  } retire_t;

  state_e        state_q, state_d;
  logic          halted_q, halted_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [31:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   pending_q, pending_d;
  retire_t       pipe_q [ALU_LATENCY];
  retire_t       pipe_d [ALU_LATENCY];

  logic          empty, full, push, pop, blocked, pipe_busy, instr_rdy, issue_vld;
  logic [31:0]   head;
  logic [15:0]   src_mask, dst_mask, clr_mask, hazard_pend;
  retire_t       wb_ent;

  function automatic logic [15:0] onehot(input logic [3:0] r);
    return 16'b1 << r;
  endfunction

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_FULL);
  assign head   = mem_q[rd_ptr_q];
  assign wb_ent = pipe_q[ALU_LATENCY-1];

  always_comb begin
    src_mask = onehot(head[3:0]) | onehot(head[7:4]) | onehot(head[11:8]) | onehot(head[15:12]);
    dst_mask = '0;
    if (head[24]) dst_mask = dst_mask | onehot(head[19:16]);
    if (head[25]) dst_mask = dst_mask | onehot(head[23:20]);
    clr_mask = '0;
    if (wb_ent.vld && wb_ent.wr[0]) clr_mask = clr_mask | onehot(wb_ent.y1);
    if (wb_ent.vld && wb_ent.wr[1]) clr_mask = clr_mask | onehot(wb_ent.y2);
    pipe_busy = 1'b0;
    for (int i = 0; i < ALU_LATENCY; i++) pipe_busy = pipe_busy | pipe_q[i].vld;
  end

`ifdef SCOREBOARD_BYPASS_EN
  // A bit retiring this cycle no longer blocks; the dependent issues alongside the retire.
  assign hazard_pend = pending_q & ~clr_mask;
`else
  assign hazard_pend = pending_q;
`endif

  assign blocked   = |((src_mask | dst_mask) & hazard_pend);
  assign instr_rdy = !full && (state_q == RUN) && !reset;
  assign issue_vld = !empty && !blocked && (state_q != HALTED) && !reset;
  assign push      = bus.instr_valid && instr_rdy;
  assign pop       = issue_vld && bus.issue_ready;

  assign bus.instr_ready         = instr_rdy;
  assign bus.program_counter_inc = push;
  assign bus.issue_valid         = issue_vld;
  assign bus.issue_instr         = head;
  assign bus.wb_valid            = wb_ent.vld && !reset;
  assign bus.wb_y1_reg           = wb_ent.y1;
  assign bus.wb_y2_reg           = wb_ent.y2;
  assign bus.wb_write            = (wb_ent.vld && !reset) ? wb_ent.wr : 2'b00;
  assign bus.halted              = halted_q && !reset;
  assign bus.pending             = pending_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.instr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    pipe_d[0] = '{vld: pop, y1: head[19:16], y2: head[23:20], wr: head[25:24]};
    for (int i = 1; i < ALU_LATENCY; i++) pipe_d[i] = pipe_q[i-1];

    // The set is applied after the clear so a same-cycle re-claim keeps the bit.
    pending_d = (pending_q & ~clr_mask) | (pop ? dst_mask : 16'h0000);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (bus.halt_req) state_d = DRAIN;
      DRAIN:   if (!bus.halt_req) state_d = RUN;
               else if (empty && !pipe_busy) state_d = HALTED;
      HALTED:  if (!bus.halt_req) state_d = RUN;
      default: state_d = RUN;
    endcase
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      halted_q  <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      for (int i = 0; i < ALU_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      pipe_q    <= pipe_d;
      mem_q     <= mem_d;
    end
  end
endmodule

// File: tb/tb_issue_sequencer.sv
// Directed and random checks of issue_sequencer against a queue-based reference model.
`timescale 1ns/1ps
module tb_issue_sequencer;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;
`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  issue_sequencer_if bus();

  issue_sequencer #(.FIFO_DEPTH(DEPTH), .ALU_LATENCY(LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int         due;
    logic [3:0] y1;
    logic [3:0] y2;
    logic [1:0] w;
  } ret_t;

  // Model: FIFO contents, outstanding retires by due cycle, per-register claim window.
  logic [31:0] m_fifo[$];
  ret_t        m_ret[$];
  int          m_iss[16];
  int          m_rel[16];
  int          m_mode;  // 0 running, 1 draining, 2 halted
  int          cyc;
  int          n_vec, n_bad;
  int          iss_cyc[$];
  int          pc_cnt, wb_cnt, p5_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit haz_pend(logic [3:0] r);
    return (m_iss[r] < cyc) && (BYP ? (cyc < m_rel[r]) : (cyc <= m_rel[r]));
  endfunction

  function automatic logic [15:0] m_pending();
    logic [15:0] p;
    p = '0;
    for (int r = 0; r < 16; r++) p[r] = (m_iss[r] < cyc) && (cyc <= m_rel[r]);
    return p;
  endfunction

  function automatic bit m_blocked(logic [31:0] w);
    bit b;
    b = 1'b0;
    for (int k = 0; k < 4; k++) if (haz_pend(w[4*k +: 4])) b = 1'b1;
    if (w[24] && haz_pend(w[19:16])) b = 1'b1;
    if (w[25] && haz_pend(w[23:20])) b = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] mk(int a, int b, int c, int d, int y1, int y2, logic [1:0] w);
    logic [31:0] x;
    x = $urandom();
    x[3:0] = 4'(a); x[7:4] = 4'(b); x[11:8] = 4'(c); x[15:12] = 4'(d);
    x[19:16] = 4'(y1); x[23:20] = 4'(y2); x[25:24] = w;
    return x;
  endfunction

  function automatic int hi();
    return int'($urandom_range(15, 8));
  endfunction

  task automatic model_clear();
    m_fifo.delete();
    m_ret.delete();
    for (int r = 0; r < 16; r++) begin
      m_iss[r] = -100;
      m_rel[r] = -100;
    end
    m_mode = 0;
  endtask

  task automatic clear_logs();
    iss_cyc.delete();
    pc_cnt = 0; wb_cnt = 0; p5_cnt = 0;
  endtask

  // Compare every output at the falling edge, then advance the model one cycle.
  task automatic tick();
    bit e_rdy, e_ivld, e_wb;
    int nxt;
    logic [31:0] w;
    @(negedge clk);
    e_rdy  = !reset && m_mode == 0 && m_fifo.size() < DEPTH;
    e_ivld = !reset && m_fifo.size() > 0 && m_mode != 2 && !m_blocked(m_fifo[0]);
    e_wb   = !reset && m_ret.size() > 0 && m_ret[0].due == cyc;
    check("instr_ready", 32'(bus.instr_ready), 32'(e_rdy));
    check("pc_inc", 32'(bus.program_counter_inc), 32'(bus.instr_valid && e_rdy));
    check("issue_valid", 32'(bus.issue_valid), 32'(e_ivld));
    if (e_ivld) check("issue_instr", bus.issue_instr, m_fifo[0]);
    check("wb_valid", 32'(bus.wb_valid), 32'(e_wb));
    check("wb_write", 32'(bus.wb_write), e_wb ? 32'(m_ret[0].w) : 32'd0);
    if (e_wb) begin
      check("wb_y1", 32'(bus.wb_y1_reg), 32'(m_ret[0].y1));
      check("wb_y2", 32'(bus.wb_y2_reg), 32'(m_ret[0].y2));
    end
    check("halted", 32'(bus.halted), 32'(!reset && m_mode == 2));
    if (!reset) check("pending", 32'(bus.pending), 32'(m_pending()));

    if (bus.issue_valid && bus.issue_ready) iss_cyc.push_back(cyc);
    if (bus.program_counter_inc) pc_cnt++;
    if (bus.wb_valid) wb_cnt++;
    if (bus.pending[5]) p5_cnt++;

    if (reset) begin
      model_clear();
    end else begin
      nxt = m_mode;
      if (m_mode == 0 && bus.halt_req) nxt = 1;
      else if (m_mode == 1 && !bus.halt_req) nxt = 0;
      else if (m_mode == 1 && m_fifo.size() == 0 && m_ret.size() == 0) nxt = 2;
      else if (m_mode == 2 && !bus.halt_req) nxt = 0;
      if (e_wb) void'(m_ret.pop_front());
      if (e_ivld && bus.issue_ready) begin
        w = m_fifo.pop_front();
        if (w[24]) begin m_iss[w[19:16]] = cyc; m_rel[w[19:16]] = cyc + LAT; end
        if (w[25]) begin m_iss[w[23:20]] = cyc; m_rel[w[23:20]] = cyc + LAT; end
        m_ret.push_back('{cyc + LAT, w[19:16], w[23:20], w[25:24]});
      end
      if (bus.instr_valid && e_rdy) m_fifo.push_back(bus.instr_data);
      m_mode = nxt;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] first_w;
  bit          seen;

  initial begin
    n_vec = 0; n_bad = 0; cyc = 0;
    model_clear();
    clear_logs();
    reset           = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr_data  = mk(hi(), hi(), hi(), hi(), 9, hi(), 2'b01);
    bus.issue_ready = 1'b1;
    bus.halt_req    = 1'b0;

    // Reset with fetch valid: nothing accepted, nothing issued.
    tick(); tick();
    check("rst_instr_ready", 32'(bus.instr_ready), 32'd0);
    check("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.instr_ready), 32'd1);
    check("post_rst_pending", 32'(bus.pending), 32'd0);
    tick();
    bus.instr_valid = 1'b0;
    check("first_issue_valid", 32'(bus.issue_valid), 32'd1);
    repeat (6) tick();

    // Eight independent words stream through at one per cycle.
    clear_logs();
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.instr_data = mk(hi(), hi(), hi(), hi(), i, hi(), 2'b01);
      tick();
    end
    bus.instr_valid = 1'b0;
    repeat (6) tick();
    check("stream_pc_pulses", pc_cnt, 8);
    check("stream_issues", iss_cyc.size(), 8);
    if (iss_cyc.size() == 8) check("stream_back_to_back", iss_cyc[7] - iss_cyc[0], 7);
    check("stream_wb_count", wb_cnt, 8);
    check("stream_pending_idle", 32'(bus.pending), 32'd0);

    // RAW on register 5.
    clear_logs();
    bus.instr_valid = 1'b1;
    bus.instr_data  = mk(hi(), hi(), hi(), hi(), 5, hi(), 2'b01);
    tick();
    bus.instr_data  = mk(5, hi(), hi(), hi(), hi(), hi(), 2'b00);
    tick();
    bus.instr_valid = 1'b0;
    repeat (10) tick();
    check("raw_issues", iss_cyc.size(), 2);
    if (iss_cyc.size() == 2) check("raw_distance", iss_cyc[1] - iss_cyc[0], BYP ? 3 : 4);
    check("raw_pending5_cycles", p5_cnt, 3);

    // Backpressure: FIFO fills to depth, head holds, then drains in order.
    clear_logs();
    bus.issue_ready = 1'b0;
    bus.instr_valid = 1'b1;
    first_w = mk(hi(), hi(), hi(), hi(), 0, hi(), 2'b01);
    for (int i = 0; i < 6; i++) begin
      bus.instr_data = (i == 0) ? first_w : mk(hi(), hi(), hi(), hi(), i, hi(), 2'b01);
      tick();
    end
    check("bp_accepts", pc_cnt, DEPTH);
    check("bp_ready_low", 32'(bus.instr_ready), 32'd0);
    check("bp_head_held", bus.issue_instr, first_w);
    bus.instr_valid = 1'b0;
    bus.issue_ready = 1'b1;
    repeat (8) tick();
    check("bp_drained", iss_cyc.size(), DEPTH);

    // Halt with three words buffered.
    bus.issue_ready = 1'b0;
    bus.instr_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.instr_data = mk(hi(), hi(), hi(), hi(), i, hi(), 2'b01);
      tick();
    end
    clear_logs();
    bus.instr_valid = 1'b0;
    bus.halt_req    = 1'b1;
    bus.issue_ready = 1'b1;
    tick();
    check("halt_ready_low", 32'(bus.instr_ready), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.halted) begin seen = 1'b1; break; end
      tick();
    end
    check("halt_reached", 32'(seen), 32'd1);
    check("halt_issues", iss_cyc.size(), 3);
    check("halt_wbs_done", wb_cnt, 3);
    bus.halt_req = 1'b0;
    tick();
    check("unhalt_halted", 32'(bus.halted), 32'd0);
    check("unhalt_ready", 32'(bus.instr_ready), 32'd1);
    repeat (2) tick();

    // Reset with two retires in flight and a blocked word buffered.
    bus.instr_valid = 1'b1;
    bus.instr_data  = mk(hi(), hi(), hi(), hi(), 4, hi(), 2'b01);
    tick();
    bus.instr_data  = mk(hi(), hi(), hi(), hi(), 5, hi(), 2'b01);
    tick();
    bus.instr_data  = mk(4, hi(), hi(), hi(), hi(), hi(), 2'b00);
    tick();
    bus.instr_valid = 1'b0;
    check("pre_rst_pending", 32'(bus.pending), 32'h0030);
    reset = 1'b1;
    tick();
    check("mid_rst_pending", 32'(bus.pending), 32'd0);
    check("mid_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_fifo_empty", 32'(bus.issue_valid), 32'd0);
    clear_logs();
    repeat (8) tick();
    check("mid_rst_no_wb", wb_cnt, 0);

    // Random traffic with hazards, backpressure, halts and occasional reset.
    for (int i = 0; i < 600; i++) begin
      bus.instr_valid = ($urandom_range(0, 3) != 0);
      bus.instr_data  = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                           $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                           2'($urandom_range(0, 3)));
      bus.issue_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) bus.halt_req = !bus.halt_req;
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset        = 1'b0;
    bus.halt_req = 1'b0;
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/issue_sequencer.md
Name: issue_sequencer

Overview:
Sequences 32-bit instructions from instruction fetch into the control path and ALU. It buffers fetched words in a small FIFO and issues them in order. A per-register scoreboard blocks issue on RAW/WAW hazards. The block retires each destination write after a fixed ALU latency and supports halt/drain for debug.

Parameters:
FIFO_DEPTH, 4, instruction buffer entries (power of 2, >=2)
ALU_LATENCY, 3, cycles from issue handshake to write-back retire (>=1)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
instr_valid  input  1  fetch word valid
instr_data  input  32  fetched instruction
instr_ready  output  1  sequencer accepts word this cycle
program_counter_inc  output  1  pulse per accepted word (instr_valid & instr_ready)
issue_valid  output  1  FIFO head valid and hazard-free
issue_instr  output  32  FIFO head instruction
issue_ready  input  1  control path accepts head
wb_valid  output  1  a retire occurs this cycle
wb_y1_reg  output  4  Y1 destination retiring
wb_y2_reg  output  4  Y2 destination retiring
wb_write  output  2  retiring write mask (bit0 Y1, bit1 Y2)
halt_req  input  1  request stop
halted  output  1  drain complete, sequencer idle
pending  output  16  scoreboard, bit r = register r write outstanding

Behaviour:
- Instruction fields: a=[3:0], b=[7:4], c=[11:8], d=[15:12], Y1=[19:16], Y2=[23:20], write=[25:24]. Sources are a, b, c, d (always checked). Destinations are Y1 if write[0] and Y2 if write[1].
- Reset: FIFO empty, pending=0, retire pipeline cleared, state RUN. Outputs during and after reset: instr_ready=0 while reset is high; issue_valid=0, wb_valid=0, wb_write=0, halted=0. Reset mid-operation discards all buffered and in-flight entries; no wb pulse is emitted for them.
- Fetch: instr_ready = !full & state==RUN & !reset. A word accepted in cycle N is visible at the FIFO head from N+1. Simultaneous push and pop when full is not allowed, because ready is low when full. Simultaneous push and pop when non-empty is allowed.
- Hazard: blocked if any source or enabled destination has its pending bit set.
- Issue: issue_valid = !empty & !blocked & state!=HALTED. Pop on issue_valid & issue_ready. issue_instr is stable while issue_valid is high and issue_ready is low. Issue is strictly in order: a blocked head stalls all younger entries.
- Scoreboard: at the issue handshake, set pending for enabled destinations. Y1==Y2 with both enabled sets one bit.
- Retire pipeline: ALU_LATENCY stages carry {valid, Y1, Y2, write}. An entry issued in cycle N produces wb_valid=1 in cycle N+ALU_LATENCY and clears its pending bits at the end of that cycle. A set and a clear of the same bit in the same cycle cannot occur without bypass.
- An instruction with write=00 still occupies a retire slot, giving wb_valid=1 with wb_write=00.
- FSM:
  - RUN: on halt_req go to DRAIN.
  - DRAIN: instr_ready=0; issue continues. When the FIFO is empty and the retire pipeline is empty, go to HALTED. If halt_req drops first, return to RUN.
  - HALTED: halted=1, no issue. When halt_req drops, go to RUN next cycle with halted=0.
- Throughput: one issue per cycle when there are no hazards and issue_ready is high.

Optional Feature:
SCOREBOARD_BYPASS_EN.
- Defined: a pending bit whose retire is in this cycle counts as clear for the hazard check. The dependent instruction can issue in the retire cycle. If it re-sets the same destination, the set wins, so the bit stays 1.
- Undefined: the dependent instruction issues no earlier than the cycle after retire.

Test Plan:
- Reset with instr_valid=1 -> instr_ready=0, pending=0, issue_valid=0. First word is accepted on the first cycle after reset; issue_valid=1 one cycle later.
- Stream of 8 independent words (write=01, Y1=0..7), issue_ready=1 -> one issue per cycle, program_counter_inc 8 pulses. wb_valid runs 3 cycles behind issue with wb_y1_reg 0..7. Final pending=0.
- RAW: issue Y1=5 (write=01), then a=5 -> second issue exactly 4 cycles after the first without bypass, 3 cycles with SCOREBOARD_BYPASS_EN. pending[5] is set for 3 cycles.
- Backpressure: fill the FIFO with issue_ready=0 -> instr_ready drops after 4 accepts. issue_instr holds the first word. Releasing issue_ready drains in order.
- Halt with 3 words buffered -> instr_ready=0 immediately, 3 issues, halted=1 after last retire. Dropping halt_req -> halted=0 and instr_ready=1 next cycle.
- Reset asserted with 2 in-flight retires and pending=0x0030 -> next cycle pending=0, wb_valid=0, FIFO empty.
